mux_nto1_nbit_reg: RTL and testbench

- Parametrised, registered successor to the 1-bit 2:1 dual-rail-select mux.
- Selects one of NUM_IN input words of WIDTH bits using a one-hot dual-rail select (Select/_Select), and registers the result with a valid flag.
- Detects and counts illegal select codes instead of driving X.
- Adds a round-robin Scan mode that steps through the channels without external select.
- Sits between datapath register banks and shared downstream logic.

---
 rtl/mux_pkg.sv | 60 ++++++
 rtl/mux_sel_decode.sv | 27 ++
 rtl/mux_nto1_nbit_reg.sv | 132 +++++++++++++
 tb/tb_mux_nto1_nbit_reg.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for dual-rail one-hot select blocks.
package mux_pkg;

    // Widest channel count the helper functions are sized for.
    localparam int MAX_IN   = 64;
    localparam int MAX_CH_W = 6;

    // Kind of request seen at a clock edge.
    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_SELECT,
        REQ_ILLEGAL,
        REQ_SCAN
    } req_kind_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // A code is legal when the rails are exact complements over the low n bits
    // and exactly one true-rail bit is set.
    function automatic logic onehot_legal(input logic [MAX_IN-1:0] sel,
                                          input logic [MAX_IN-1:0] nsel,
                                          input int n);
        int   ones;
        logic rails_ok;
        ones     = 0;
        rails_ok = 1'b1;
        for (int i = 0; i < MAX_IN; i++) begin
            if (i < n) begin
                if (nsel[i] == sel[i]) begin
                    rails_ok = 1'b0;
                end
                if (sel[i]) begin
                    ones++;
                end
            end
        end
        return rails_ok && (ones == 1);
    endfunction

    // Index of the set bit of a one-hot word; meaningless for non-one-hot input.
    function automatic logic [MAX_CH_W-1:0] onehot_to_idx(input logic [MAX_IN-1:0] sel);
        logic [MAX_CH_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_IN; i++) begin
            if (sel[i]) begin
                idx = MAX_CH_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_sel_decode.sv
// Combinational decoder for a dual-rail one-hot select: legality plus channel index.
module mux_sel_decode
    import mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_IN-1:0] sel,
    input  logic [NUM_IN-1:0] nsel,
    output logic              legal,
    output logic [CH_W-1:0]   idx
);

    logic [MAX_IN-1:0] sel_ext;
    logic [MAX_IN-1:0] nsel_ext;

    // Widen both rails to the helper width, then classify and encode the code.
    always_comb begin
        sel_ext               = '0;
        nsel_ext              = '0;
        sel_ext[NUM_IN-1:0]   = sel;
        nsel_ext[NUM_IN-1:0]  = nsel;
        legal                 = onehot_legal(sel_ext, nsel_ext, NUM_IN);
        idx                   = CH_W'(onehot_to_idx(sel_ext));
    end

endmodule

// File: rtl/mux_nto1_nbit_reg.sv
// Registered N:1 word mux with dual-rail one-hot select, illegal-select
// detection with a saturating counter, and a round-robin scan mode.
module mux_nto1_nbit_reg
    import mux_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int NUM_IN    = 4,
    parameter  int ERR_CNT_W = 4,
    localparam int CH_W      = (clog2(NUM_IN) < 1) ? 1 : clog2(NUM_IN)
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [NUM_IN*WIDTH-1:0] In,
    input  logic [NUM_IN-1:0]       Select,
    input  logic [NUM_IN-1:0]       _Select,
    input  logic                    InValid,
    input  logic                    Scan,
    input  logic                    ClearErr,
    output logic [WIDTH-1:0]        Out,
    output logic                    OutValid,
    output logic [CH_W-1:0]         OutChan,
    output logic                    SelError,
    output logic [ERR_CNT_W-1:0]    ErrCount
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CH_W-1:0]      LAST_CH = CH_W'(NUM_IN - 1);

    logic [WIDTH-1:0]     words [NUM_IN];
    logic                 sel_legal;
    logic [CH_W-1:0]      sel_idx;
    req_kind_t            req;
    logic [CH_W-1:0]      scan_ptr;
    logic [CH_W-1:0]      scan_ptr_next;
    logic [WIDTH-1:0]     out_next;
    logic [CH_W-1:0]      chan_next;
    logic                 valid_next;
    logic                 err_next;
    logic [ERR_CNT_W-1:0] cnt_next;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_words
        assign words[k] = In[k*WIDTH +: WIDTH];
    end

    mux_sel_decode #(
        .NUM_IN (NUM_IN),
        .CH_W   (CH_W)
    ) u_decode (
        .sel   (Select),
        .nsel  (_Select),
        .legal (sel_legal),
        .idx   (sel_idx)
    );

    // Classify this cycle's request; rails only matter in select mode with InValid.
    always_comb begin
        req = REQ_IDLE;
        if (InValid) begin
            if (Scan) begin
                req = REQ_SCAN;
            end else if (sel_legal) begin
                req = REQ_SELECT;
            end else begin
                req = REQ_ILLEGAL;
            end
        end
    end

    // Next-state for data, channel, valid, error flag, counter and scan pointer.
    always_comb begin
        out_next      = Out;
        chan_next     = OutChan;
        valid_next    = 1'b0;
        err_next      = SelError;
        cnt_next      = ErrCount;
        scan_ptr_next = scan_ptr;
        if (ClearErr) begin
            err_next = 1'b0;
            cnt_next = '0;
        end
        case (req)
            REQ_SCAN: begin
                out_next      = words[scan_ptr];
                chan_next     = scan_ptr;
                valid_next    = 1'b1;
                scan_ptr_next = (scan_ptr == LAST_CH) ? '0 : scan_ptr + 1'b1;
            end
            REQ_SELECT: begin
                out_next   = words[sel_idx];
                chan_next  = sel_idx;
                valid_next = 1'b1;
            end
            REQ_ILLEGAL: begin
                err_next = 1'b1;
                if (ClearErr) begin
                    cnt_next = ERR_CNT_W'(1);
                end else if (ErrCount != CNT_MAX) begin
                    cnt_next = ErrCount + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Scan pointer register; only moves on scan captures.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            scan_ptr <= '0;
        end else begin
            scan_ptr <= scan_ptr_next;
        end
    end

    // Output flops so that nothing combinational reaches the ports.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Out      <= '0;
            OutValid <= 1'b0;
            OutChan  <= '0;
            SelError <= 1'b0;
            ErrCount <= '0;
        end else begin
            Out      <= out_next;
            OutValid <= valid_next;
            OutChan  <= chan_next;
            SelError <= err_next;
            ErrCount <= cnt_next;
        end
    end

endmodule

// File: tb/tb_mux_nto1_nbit_reg.sv
// Directed plus random bench for mux_nto1_nbit_reg against a behavioural model.
module tb_mux_nto1_nbit_reg;

    localparam int WIDTH     = 8;
    localparam int NUM_IN    = 4;
    localparam int ERR_CNT_W = 4;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

    logic                    clk;
    logic                    rst;
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [NUM_IN-1:0]       sel;
    logic [NUM_IN-1:0]       nsel;
    logic                    in_valid;
    logic                    scan;
    logic                    clear_err;
    logic [WIDTH-1:0]        out_word;
    logic                    out_valid;
    logic [1:0]              out_chan;
    logic                    sel_error;
    logic [ERR_CNT_W-1:0]    err_count;

    // Reference model state
    int m_out;
    int m_chan;
    int m_valid;
    int m_err;
    int m_cnt;
    int m_ptr;

    int checks;
    int errors;

    mux_nto1_nbit_reg #(
        .WIDTH     (WIDTH),
        .NUM_IN    (NUM_IN),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .Clock    (clk),
        .Reset    (rst),
        .In       (in_bus),
        .Select   (sel),
        ._Select  (nsel),
        .InValid  (in_valid),
        .Scan     (scan),
        .ClearErr (clear_err),
        .Out      (out_word),
        .OutValid (out_valid),
        .OutChan  (out_chan),
        .SelError (sel_error),
        .ErrCount (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        m_out   = 0;
        m_chan  = 0;
        m_valid = 0;
        m_err   = 0;
        m_cnt   = 0;
        m_ptr   = 0;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (int'(out_word) === m_out) else begin
            errors++;
            $error("[TB] FAIL %s Out: got %0h expected %0h", tag, out_word, m_out);
        end
        checks++;
        assert (int'(out_valid) === m_valid) else begin
            errors++;
            $error("[TB] FAIL %s OutValid: got %0d expected %0d", tag, out_valid, m_valid);
        end
        checks++;
        assert (int'(out_chan) === m_chan) else begin
            errors++;
            $error("[TB] FAIL %s OutChan: got %0d expected %0d", tag, out_chan, m_chan);
        end
        checks++;
        assert (int'(sel_error) === m_err) else begin
            errors++;
            $error("[TB] FAIL %s SelError: got %0d expected %0d", tag, sel_error, m_err);
        end
        checks++;
        assert (int'(err_count) === m_cnt) else begin
            errors++;
            $error("[TB] FAIL %s ErrCount: got %0d expected %0d", tag, err_count, m_cnt);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the rules, and compare.
    task automatic applyStimulus(input logic [NUM_IN-1:0] s, input logic [NUM_IN-1:0] ns,
                                 input logic v, input logic sc, input logic clr,
                                 input string tag);
        bit legal;
        int chan;
        sel       = s;
        nsel      = ns;
        in_valid  = v;
        scan      = sc;
        clear_err = clr;
        @(posedge clk);
        #1;
        legal = ($countones(s) == 1) && (ns === ~s);
        chan  = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (s[k]) chan = k;
        end
        m_valid = 0;
        if (v && sc) begin
            m_out   = int'(in_bus[m_ptr*WIDTH +: WIDTH]);
            m_chan  = m_ptr;
            m_valid = 1;
            m_ptr   = (m_ptr + 1) % NUM_IN;
            if (clr) begin m_err = 0; m_cnt = 0; end
        end else if (v && legal) begin
            m_out   = int'(in_bus[chan*WIDTH +: WIDTH]);
            m_chan  = chan;
            m_valid = 1;
            if (clr) begin m_err = 0; m_cnt = 0; end
        end else if (v) begin
            m_err = 1;
            m_cnt = clr ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
        end else if (clr) begin
            m_err = 0;
            m_cnt = 0;
        end
        checkOutput(tag);
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic asyncReset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput(tag);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [NUM_IN-1:0] rs;
        logic [NUM_IN-1:0] rns;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_bus    = '0;
        sel       = '0;
        nsel      = '1;
        in_valid  = 1'b0;
        scan      = 1'b0;
        clear_err = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state");
        rst = 1'b0;

        // Some traffic, then an asynchronous reset mid-stream
        in_bus = 32'h5566_7788;
        applyStimulus(4'b0001, 4'b1110, 1'b1, 1'b0, 1'b0, "pre_sel0");
        applyStimulus(4'b1000, 4'b0111, 1'b1, 1'b0, 1'b0, "pre_sel3");
        applyStimulus(4'b0011, 4'b1100, 1'b1, 1'b0, 1'b0, "pre_illegal");
        asyncReset("reset_midstream");

        // Legal select of channel 2
        in_bus = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        applyStimulus(4'b0100, 4'b1011, 1'b1, 1'b0, 1'b0, "sel_ch2");

        // Three kinds of illegal codes
        applyStimulus(4'b0110, 4'b1001, 1'b1, 1'b0, 1'b0, "ill_multihot");
        applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, "ill_zero");
        applyStimulus(4'b0010, 4'b1111, 1'b1, 1'b0, 1'b0, "ill_rails");

        // Saturation
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, "saturate");
        end

        // Clear alone, then clear colliding with an illegal request
        applyStimulus(4'b0001, 4'b1110, 1'b0, 1'b0, 1'b1, "clear_only");
        applyStimulus(4'b0101, 4'b1010, 1'b1, 1'b0, 1'b1, "clear_vs_illegal");

        // Idle cycle with garbage rails must not flag an error
        applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, "idle_garbage");

        // Scan wrap with garbage rails
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'(i * 5 + 3), 4'(i * 7), 1'b1, 1'b1, 1'b0, "scan_wrap");
        end

        // Gaps hold the pointer
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, "scan_gap");
        end

        // Leave scan for a select, then resume from the held pointer
        applyStimulus(4'b0001, 4'b1110, 1'b1, 1'b0, 1'b0, "mode_sel_ch0");
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, "mode_resume");

        // Reset mid-scan with the pointer at 3
        asyncReset("reset_midscan");
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, "scan_after_reset");

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            in_bus = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                rs  = 4'(1 << $urandom_range(0, NUM_IN - 1));
                rns = ~rs;
            end else begin
                rs  = 4'($urandom);
                rns = 4'($urandom);
            end
            applyStimulus(rs, rns, 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 9) == 0), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
